rice_core_trap_ctrl: RTL
========================

# rice_core_trap_ctrl

Machine-mode trap sequencer for the rice core. It accepts synchronous exceptions, one machine external interrupt and MRET from the pipeline, and writes the M-level CSR hardware-set ports (mepc, mcause, mtval, mstatus.MIE/MPIE/MPP). It then issues a PC redirect to fetch. It sits beside the core's CSR environment and is the only driver of those CSR set strobes.

## Interface
- XLEN, 32, data/PC width
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_exception_valid  in  1  exception request, held until o_ack
- i_exception_code  in  4  exception cause code
- i_exception_tval  in  XLEN  trap value for mtval
- i_mret_valid  in  1  MRET request, held until o_ack
- i_irq  in  1  machine external interrupt level (cause 11)
- i_event_pc  in  XLEN  PC of the faulting, MRET or interrupted instruction
- o_ack  out  1  one-cycle pulse: request consumed
- o_busy  out  1  high whenever state != IDLE
- i_mtvec_mode  in  2  mtvec.MODE
- i_mtvec_base  in  XLEN-2  mtvec.BASE
- i_mepc  in  XLEN  current mepc
- i_mstatus_mie, i_mstatus_mpie  in  1 each  current mstatus bits
- o_mepc_set, o_mcause_exception_code_set, o_mcause_interrupt_set, o_mtval_set, o_mstatus_mie_set, o_mstatus_mpie_set, o_mstatus_mpp_set  out  1 each  CSR write strobes
- o_mepc, o_mtval  out  XLEN; o_mcause_exception_code  out  4; o_mcause_interrupt, o_mstatus_mie, o_mstatus_mpie  out  1; o_mstatus_mpp  out  2  CSR write data
- o_redirect_valid  out  1; o_redirect_pc  out  XLEN; i_redirect_ready  in  1  fetch redirect handshake

## Operation
- FSM states: IDLE, SAVE, REDIRECT.
- **IDLE:** arbitrate by fixed priority: exception > MRET > interrupt.
  - An interrupt is eligible only when i_irq=1 and i_mstatus_mie=1.
  - On a winner: pulse o_ack, latch kind, code, pc, tval and the target, then go to SAVE.
  - Losing requests are not acked.
- **SAVE (exactly 1 cycle), trap (exception or interrupt):** assert every set strobe.
  - mepc = {pc[XLEN-1:1],1'b0}.
  - mcause code = exception code, or 4'd11 for the interrupt.
  - mcause interrupt bit = 1 for the interrupt, else 0.
  - mtval = tval for an exception, 0 for the interrupt.
  - MIE = 0; MPIE = latched mie; MPP = 2'b11.
- **SAVE, MRET:** only the MIE, MPIE and MPP strobes. MIE = latched mpie; MPIE = 1; MPP = 2'b11.
- After SAVE, go to REDIRECT.
- **REDIRECT:** hold o_redirect_valid=1 with a stable o_redirect_pc until i_redirect_ready=1, then go to IDLE.
- **Trap target (latched at accept):**
  - mode 0, or reserved modes 2/3: {base,2'b00}.
  - mode 1 with an exception: {base,2'b00}.
  - mode 1 with the interrupt: {base,2'b00} + (11<<2), computed modulo 2^XLEN.
- **MRET target:** {i_mepc[XLEN-1:1],1'b0}, latched at accept.
- Set-data outputs are don't-care when their strobe is low; drive them as 0.

## Timing
- **Reset:** the cycle after i_rst_n=0 is sampled, the state is IDLE and every output is 0, including o_busy, o_ack, all strobes and o_redirect_valid.
  - Reset mid-SAVE or mid-REDIRECT abandons the sequence: no further strobes, no redirect.
- **Latency:**
  - Accept at cycle N: o_ack high in N.
  - Strobes high in N+1 only.
  - o_redirect_valid high from N+2.
  - If i_redirect_ready=1 at N+2, the state is IDLE at N+3 and the earliest next accept is N+3.
- **Busy window:** o_busy is high from N+1 until the handshake cycle inclusive. No request is acked while busy; requesters hold.
- **Simultaneous exception, MRET and irq:** only the exception is acked. MRET stays pending and is acked at the next IDLE.
- **Interrupt eligibility:** sampled only in IDLE. i_irq dropping after accept does not cancel the trap.

## Structure
- rice_core_pkg additions:
  - rice_trap_state enum (IDLE/SAVE/REDIRECT).
  - rice_trap_kind enum (EXCEPTION/MRET/INTERRUPT).
  - RICE_MTVEC_DIRECT=2'd0 and RICE_MTVEC_VECTORED=2'd1.
  - RICE_MEXT_INT_CODE=4'd11.
  - RICE_PRIV_M=2'b11.
- No sub-module; single flat FSM with latched request registers.

## Test plan
- **Reset:** hold i_rst_n=0 for 3 cycles with all requests high -> every output 0, no o_ack.
- **Direct exception:** exception code 4'd2, pc 0x100, tval 0xDEAD, mode 0, base 0x20 (target 0x80), mie=1 ->
  - o_ack at N.
  - SAVE at N+1: mepc 0x100, code 2, interrupt 0, mtval 0xDEAD, MIE 0, MPIE 1, MPP 3.
  - Redirect 0x80 at N+2.
- **Vectored interrupt:** mode 1, base 0x40 (0x100), i_irq=1, mie=1 -> redirect 0x12C, mcause interrupt 1, code 11, mtval 0.
- **Masked interrupt:** i_irq=1 with mie=0 for 10 cycles -> no ack, o_busy 0.
- **MRET:** i_mepc=0x203, mpie=1 -> only the MIE/MPIE/MPP strobes fire, with MIE 1, MPIE 1, MPP 3; redirect 0x202.
- **Priority, backpressure and reset:**
  - Exception, MRET and irq asserted together -> exception acked, MRET acked 3 cycles later.
  - i_redirect_ready held 0 for 5 cycles -> redirect valid and PC stable throughout.
  - Reset asserted in REDIRECT -> IDLE, outputs 0.

Source files
------------

// File: rtl/rice_core_pkg.sv
// Shared types and constants for the rice core machine-mode trap logic.
package rice_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    REDIRECT
  } rice_trap_state;

  typedef enum logic [1:0] {
    EXCEPTION,
    MRET,
    INTERRUPT
  } rice_trap_kind;

  localparam logic [1:0] RICE_MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] RICE_MTVEC_VECTORED = 2'd1;
  localparam logic [3:0] RICE_MEXT_INT_CODE  = 4'd11;
  localparam logic [1:0] RICE_PRIV_M         = 2'b11;

endpackage

// File: rtl/rice_core_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, MRET and the external
// interrupt, writes the M-level CSR hardware-set ports for one cycle, then
// holds a PC redirect towards fetch until it is accepted.
module rice_core_trap_ctrl
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  input  logic            i_exception_valid,
  input  logic [3:0]      i_exception_code,
  input  logic [XLEN-1:0] i_exception_tval,
  input  logic            i_mret_valid,
  input  logic            i_irq,
  input  logic [XLEN-1:0] i_event_pc,
  output logic            o_ack,
  output logic            o_busy,

  input  logic [1:0]      i_mtvec_mode,
  input  logic [XLEN-3:0] i_mtvec_base,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_mstatus_mie,
  input  logic            i_mstatus_mpie,

  output logic            o_mepc_set,
  output logic            o_mcause_exception_code_set,
  output logic            o_mcause_interrupt_set,
  output logic            o_mtval_set,
  output logic            o_mstatus_mie_set,
  output logic            o_mstatus_mpie_set,
  output logic            o_mstatus_mpp_set,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mtval,
  output logic [3:0]      o_mcause_exception_code,
  output logic            o_mcause_interrupt,
  output logic            o_mstatus_mie,
  output logic            o_mstatus_mpie,
  output logic [1:0]      o_mstatus_mpp,

  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_ready
);

  // Vectored mode places the external interrupt handler at base + cause*4.
  localparam logic [XLEN-1:0] IRQ_VEC_OFFSET = {{(XLEN-6){1'b0}}, RICE_MEXT_INT_CODE, 2'b00};

  rice_trap_state  state_q;
  rice_trap_kind   kind_q,   kind_d;
  logic [3:0]      code_q,   code_d;
  logic [XLEN-1:0] mepc_q,   mepc_d;
  logic [XLEN-1:0] tval_q,   tval_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            mie_q;
  logic            mpie_q;

  logic            excWin;
  logic            mretWin;
  logic            irqWin;
  logic            acceptReq;
  logic [XLEN-1:0] baseAddr;
  logic            unusedPcBits;

  // The MRET target and saved mepc are always halfword aligned, so bit 0 of
  // the incoming PCs is dropped on purpose.
  assign unusedPcBits = i_event_pc[0] ^ i_mepc[0];

  assign baseAddr = {i_mtvec_base, 2'b00};

  // Fixed-priority arbitration and the values captured when a request wins.
  always_comb begin
    excWin    = i_exception_valid;
    mretWin   = !i_exception_valid && i_mret_valid;
    irqWin    = !i_exception_valid && !i_mret_valid && i_irq && i_mstatus_mie;
    acceptReq = (state_q == IDLE) && i_rst_n && (excWin || mretWin || irqWin);

    kind_d   = EXCEPTION;
    code_d   = i_exception_code;
    mepc_d   = {i_event_pc[XLEN-1:1], 1'b0};
    tval_d   = i_exception_tval;
    target_d = baseAddr;

    if (mretWin) begin
      kind_d   = MRET;
      code_d   = 4'd0;
      tval_d   = '0;
      target_d = {i_mepc[XLEN-1:1], 1'b0};
    end else if (irqWin) begin
      kind_d = INTERRUPT;
      code_d = RICE_MEXT_INT_CODE;
      tval_d = '0;
      if (i_mtvec_mode == RICE_MTVEC_VECTORED) begin
        target_d = baseAddr + IRQ_VEC_OFFSET;
      end
    end
  end

  // Sequencer state and latched request context; reset abandons any sequence.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      kind_q   <= EXCEPTION;
      code_q   <= '0;
      mepc_q   <= '0;
      tval_q   <= '0;
      target_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acceptReq) begin
            state_q  <= SAVE;
            kind_q   <= kind_d;
            code_q   <= code_d;
            mepc_q   <= mepc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
            mie_q    <= i_mstatus_mie;
            mpie_q   <= i_mstatus_mpie;
          end
        end
        SAVE: begin
          state_q <= REDIRECT;
        end
        REDIRECT: begin
          if (i_redirect_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // CSR strobes and data in SAVE, redirect in REDIRECT; everything else is 0.
  always_comb begin
    o_mepc_set                  = 1'b0;
    o_mcause_exception_code_set = 1'b0;
    o_mcause_interrupt_set      = 1'b0;
    o_mtval_set                 = 1'b0;
    o_mstatus_mie_set           = 1'b0;
    o_mstatus_mpie_set          = 1'b0;
    o_mstatus_mpp_set           = 1'b0;
    o_mepc                      = '0;
    o_mtval                     = '0;
    o_mcause_exception_code     = '0;
    o_mcause_interrupt          = 1'b0;
    o_mstatus_mie               = 1'b0;
    o_mstatus_mpie              = 1'b0;
    o_mstatus_mpp               = 2'b00;
    o_redirect_valid            = 1'b0;
    o_redirect_pc               = '0;

    if (state_q == SAVE) begin
      o_mstatus_mie_set  = 1'b1;
      o_mstatus_mpie_set = 1'b1;
      o_mstatus_mpp_set  = 1'b1;
      o_mstatus_mpp      = RICE_PRIV_M;
      if (kind_q == MRET) begin
        o_mstatus_mie  = mpie_q;
        o_mstatus_mpie = 1'b1;
      end else begin
        o_mepc_set                  = 1'b1;
        o_mcause_exception_code_set = 1'b1;
        o_mcause_interrupt_set      = 1'b1;
        o_mtval_set                 = 1'b1;
        o_mepc                      = mepc_q;
        o_mtval                     = tval_q;
        o_mcause_exception_code     = code_q;
        o_mcause_interrupt          = (kind_q == INTERRUPT);
        o_mstatus_mie               = 1'b0;
        o_mstatus_mpie              = mie_q;
      end
    end else if (state_q == REDIRECT) begin
      o_redirect_valid = 1'b1;
      o_redirect_pc    = target_q;
    end
  end

  assign o_ack  = acceptReq;
  assign o_busy = (state_q != IDLE);

endmodule
